// File: rtl/sprite_anim_sequencer.sv
// Animated-sprite sequencer: picks the displayed frame, holds it for HOLD_TICKS
// clocks, commits changes only at video frame start, and builds the upscaled ROM address.
module sprite_anim_sequencer #(
  parameter int pA         = 10,
  parameter int NUM_FRAMES = 6,
  parameter int HOLD_TICKS = 20_000_000,
  parameter int CW         = 28,
  parameter int SCALE      = 5,
  parameter int SPR_W      = 128,
  parameter int SPR_H      = 96,
  parameter int AW         = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [pA-1:0] pix_x,
  input  logic [pA-1:0] pix_y,
  input  logic          pix_v,
  input  logic          frame_start,
  input  logic          run,
  input  logic          oneshot,
  output logic [2:0]    frame_sel,
  output logic [AW-1:0] rom_addr,
  output logic          addr_valid,
  output logic          wrap,
  output logic          done
);

  localparam int XW   = $clog2(SCALE + 1);
  localparam int COLW = $clog2(SPR_W + 1);
  localparam int ROWW = $clog2(SPR_H + 1);
  localparam int BW   = $clog2(SPR_W * SPR_H + SPR_W + 1);

  localparam logic [CW-1:0]   HOLD_MAX   = CW'(HOLD_TICKS - 1);
  localparam logic [2:0]      LAST_FRAME = 3'(NUM_FRAMES - 1);
  localparam logic [XW-1:0]   SUB_MAX    = XW'(SCALE - 1);
  localparam logic [COLW-1:0] COL_MAX    = COLW'(SPR_W);
  localparam logic [ROWW-1:0] ROW_MAX    = ROWW'(SPR_H);
  localparam logic [BW-1:0]   LINE_STEP  = BW'(SPR_W);

  typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] hold_cnt, hold_d;
  logic          pending, pending_d;
  logic [2:0]    frame_d;
  logic          done_d, wrap_d;
  logic          expiry, advance;

  assign expiry  = (hold_cnt == HOLD_MAX);
  // Uses the registered pending, so an expiry coinciding with frame_start waits a frame.
  assign advance = frame_start && pending;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      frame_sel <= '0;
      hold_cnt  <= '0;
      pending   <= 1'b0;
      done      <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_sel <= frame_d;
      hold_cnt  <= hold_d;
      pending   <= pending_d;
      done      <= done_d;
      wrap      <= wrap_d;
    end
  end

  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_sel;
    hold_d    = hold_cnt;
    pending_d = pending;
    done_d    = done;
    wrap_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        hold_d    = '0;
        pending_d = 1'b0;
        done_d    = 1'b0;
        if (frame_start) frame_d = '0;
        if (run) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (!run) begin
          state_d   = ST_IDLE;
          hold_d    = '0;
          pending_d = 1'b0;
        end else begin
          hold_d    = expiry ? '0 : hold_cnt + CW'(1);
          pending_d = expiry || (pending && !advance);
          if (advance) begin
            if (frame_sel < LAST_FRAME) begin
              frame_d = frame_sel + 3'd1;
            end else if (!oneshot) begin
              frame_d = '0;
              wrap_d  = 1'b1;
            end else begin
              done_d    = 1'b1;
              pending_d = 1'b0;
              state_d   = ST_DONE;
            end
          end
        end
      end
      ST_DONE: begin
        pending_d = 1'b0;
        if (!run) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  logic [XW-1:0]   xsub, ysub, xsub_cur;
  logic [COLW-1:0] col, col_cur;
  logic [ROWW-1:0] row;
  logic [BW-1:0]   base;
  logic            pix_v_q;
  logic            line_start;

  // Column position restarts on the first pixel of a line, so that pixel uses column 0.
  assign line_start = pix_v && (pix_x == '0);
  assign xsub_cur   = line_start ? '0 : xsub;
  assign col_cur    = line_start ? '0 : col;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xsub       <= '0;
      col        <= '0;
      ysub       <= '0;
      row        <= '0;
      base       <= '0;
      pix_v_q    <= 1'b0;
      rom_addr   <= '0;
      addr_valid <= 1'b0;
    end else begin
      pix_v_q    <= pix_v;
      addr_valid <= pix_v && (col_cur < COL_MAX) && (row < ROW_MAX);
      if (pix_v) begin
        rom_addr <= AW'(base + BW'(col_cur));
        if (xsub_cur == SUB_MAX) begin
          xsub <= '0;
          col  <= (col_cur == COL_MAX) ? col_cur : col_cur + COLW'(1);
        end else begin
          xsub <= xsub_cur + XW'(1);
          col  <= col_cur;
        end
      end
      if (frame_start) begin
        row  <= '0;
        ysub <= '0;
        base <= '0;
      end else if (pix_v_q && !pix_v) begin
        if (ysub == SUB_MAX) begin
          ysub <= '0;
          if (row != ROW_MAX) begin
            row  <= row + ROWW'(1);
            base <= base + LINE_STEP;
          end
        end else begin
          ysub <= ysub + XW'(1);
        end
      end
    end
  end

  // Row position comes from the line counters; the row input is not needed.
  logic unused_pix_y;
  assign unused_pix_y = ^pix_y;

endmodule

// File: tb/tb_sprite_anim_sequencer.sv
// Self-checking bench for sprite_anim_sequencer: frame-level model plus raster address model,
// compared every cycle, with hand-computed literals pinning key points.
module tb_sprite_anim_sequencer;

  localparam int NF = 3;
  localparam int HT = 4;
  localparam int SC = 5;
  localparam int SW = 128;
  localparam int SH = 96;
  localparam int AW = 14;
  localparam int PA = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [PA-1:0] pix_x, pix_y;
  logic          pix_v, frame_start, run, oneshot;
  logic [2:0]    frame_sel;
  logic [AW-1:0] rom_addr;
  logic          addr_valid, wrap, done;

  sprite_anim_sequencer #(
    .pA(PA), .NUM_FRAMES(NF), .HOLD_TICKS(HT), .CW(4),
    .SCALE(SC), .SPR_W(SW), .SPR_H(SH), .AW(AW)
  ) dut (
    .clk(clk), .rst(rst), .pix_x(pix_x), .pix_y(pix_y), .pix_v(pix_v),
    .frame_start(frame_start), .run(run), .oneshot(oneshot),
    .frame_sel(frame_sel), .rom_addr(rom_addr), .addr_valid(addr_valid),
    .wrap(wrap), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame model: playing/stopped flags, tick count modulo HT, one pending flag.
  bit m_playing = 0, m_stopped = 0, m_pending = 0, m_wrap = 0, m_done = 0;
  int m_ticks = 0, m_frame = 0;
  bit m_expired;
  bit m_fs_edge = 0;
  // Address model: address from pixel coordinates by plain division.
  bit e_valid = 0;
  int e_addr = 0;
  bit lit_req = 0, lit_now = 0;
  int lit_exp = 0, lit_exp_q = 0;
  bit checking = 0;
  logic [2:0] prev_sel = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_playing = 0; m_stopped = 0; m_pending = 0; m_wrap = 0; m_done = 0;
      m_ticks = 0; m_frame = 0; m_fs_edge = 0;
      e_valid = 0; e_addr = 0; lit_now = 0;
    end else begin
      m_fs_edge = frame_start;
      m_wrap = 0;
      if (m_stopped) begin
        if (!run) begin m_stopped = 0; m_done = 0; end
      end else if (m_playing) begin
        if (!run) begin
          m_playing = 0; m_ticks = 0; m_pending = 0;
        end else begin
          m_expired = (m_ticks == HT - 1);
          m_ticks = (m_ticks + 1) % HT;
          if (frame_start && m_pending) begin
            m_pending = 0;
            if (m_frame < NF - 1) m_frame = m_frame + 1;
            else if (!oneshot) begin m_frame = 0; m_wrap = 1; end
            else begin m_done = 1; m_stopped = 1; m_playing = 0; end
          end
          if (m_expired && m_playing) m_pending = 1;
        end
      end else begin
        if (frame_start) m_frame = 0;
        if (run) m_playing = 1;
      end
      e_valid = pix_v && (int'(pix_x) / SC < SW) && (int'(pix_y) / SC < SH);
      if (e_valid) e_addr = int'(pix_x) / SC + (int'(pix_y) / SC) * SW;
      lit_now = lit_req;
      lit_exp_q = lit_exp;
    end
  end

  always @(negedge clk) begin
    if (!rst && checking) begin
      check("frame_sel", frame_sel, m_frame);
      check("wrap", wrap, m_wrap);
      check("done", done, m_done);
      check("addr_valid", addr_valid, e_valid);
      if (e_valid) check("rom_addr", rom_addr, e_addr);
      if (lit_now) begin
        check("pixel_literal_addr", rom_addr, lit_exp_q);
        check("pixel_literal_valid", addr_valid, 1);
      end
      if (frame_sel !== prev_sel) check("tear_free_change_at_fs", m_fs_edge, 1);
    end
    prev_sel = frame_sel;
  end

  // One frame_start pulse, then a literal check of the committed frame, padded to 'period' clocks.
  task automatic frame_pulse(input int period, input int exp_sel, input int exp_wrap);
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    @(negedge clk);
    check("fs_frame_sel", frame_sel, exp_sel);
    check("fs_wrap", wrap, exp_wrap);
    repeat (period - 2) @(posedge clk);
  endtask

  function automatic int pin_addr(input int x, input int y);
    if (x == 0   && y == 0)   return 0;
    if (x == 4   && y == 4)   return 0;
    if (x == 5   && y == 0)   return 1;
    if (x == 639 && y == 0)   return 127;
    if (x == 0   && y == 5)   return 128;
    if (x == 639 && y == 479) return 12287;
    return -1;
  endfunction

  int w, pa;

  initial begin
    rst = 1'b1; pix_x = '0; pix_y = '0; pix_v = 1'b0;
    frame_start = 1'b0; run = 1'b0; oneshot = 1'b0;
    #12;
    check("rst_frame_sel", frame_sel, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_addr_valid", addr_valid, 0);
    check("rst_wrap", wrap, 0);
    check("rst_done", done, 0);
    @(posedge clk); #3 rst = 1'b0;
    checking = 1;

    // Loop timing: 0,1,2,0 with wrap on the 2->0 step.
    @(posedge clk); #1 run = 1'b1;
    frame_pulse(10, 0, 0);
    frame_pulse(10, 1, 0);
    frame_pulse(10, 2, 0);
    frame_pulse(10, 0, 1);

    // Many expiries per video frame still give one advance.
    frame_pulse(30, 1, 0);
    frame_pulse(30, 2, 0);
    frame_pulse(30, 0, 1);

    // Oneshot: stop on the last frame, then release.
    oneshot = 1'b1;
    frame_pulse(10, 1, 0);
    frame_pulse(10, 2, 0);
    frame_pulse(10, 2, 0);
    check("oneshot_done_set", done, 1);
    frame_pulse(10, 2, 0);
    check("oneshot_done_held", done, 1);
    @(posedge clk); #1 run = 1'b0;
    @(posedge clk); @(negedge clk);
    check("done_clear_next_cycle", done, 0);
    check("frame_kept_until_fs", frame_sel, 2);
    frame_pulse(10, 0, 0);
    oneshot = 1'b0;

    // Raster scan: some lines shortened to stay in budget, line 6 overruns the sprite width.
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    for (int y = 0; y < 480; y++) begin
      w = (y == 6) ? 660 : ((y < 6 || y >= 474) ? 640 : 10);
      for (int x = 0; x < w; x++) begin
        @(posedge clk); #1;
        pix_v = 1'b1; pix_x = PA'(x); pix_y = PA'(y);
        pa = pin_addr(x, y);
        lit_req = (pa >= 0);
        lit_exp = pa;
      end
      @(posedge clk); #1 pix_v = 1'b0; lit_req = 1'b0;
      @(posedge clk); #1;
      check("blank_addr_valid", addr_valid, 0);
      if (y == 0) check("blank_addr_hold", rom_addr, 127);
    end

    // Asynchronous reset in the middle of PLAY at frame 2.
    @(posedge clk); #1 run = 1'b1;
    frame_pulse(10, 0, 0);
    frame_pulse(10, 1, 0);
    frame_pulse(10, 2, 0);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    check("async_rst_frame_sel", frame_sel, 0);
    check("async_rst_wrap", wrap, 0);
    check("async_rst_done", done, 0);
    check("async_rst_addr_valid", addr_valid, 0);
    @(posedge clk); #3 rst = 1'b0;
    frame_pulse(10, 0, 0);
    frame_pulse(10, 1, 0);

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
